// File: rtl/alu_design_pkg.sv
// Shared encodings for alu_design: mode select, command codes, operand-valid codes, flag bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_design_pkg;

  // MODE input
  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  // Arithmetic commands (MODE_ARITH)
  localparam int unsigned CMD_ADD     = 0;
  localparam int unsigned CMD_SUB     = 1;
  localparam int unsigned CMD_ADD_CIN = 2;
  localparam int unsigned CMD_SUB_CIN = 3;
  localparam int unsigned CMD_INC_A   = 4;
  localparam int unsigned CMD_DEC_A   = 5;
  localparam int unsigned CMD_INC_B   = 6;
  localparam int unsigned CMD_DEC_B   = 7;
  localparam int unsigned CMD_CMP     = 8;
  localparam int unsigned CMD_MUL_INC = 9;
  localparam int unsigned CMD_MUL_SHL = 10;

  // Logical commands (MODE_LOGIC)
  localparam int unsigned CMD_AND     = 0;
  localparam int unsigned CMD_NAND    = 1;
  localparam int unsigned CMD_OR      = 2;
  localparam int unsigned CMD_NOR     = 3;
  localparam int unsigned CMD_XOR     = 4;
  localparam int unsigned CMD_XNOR    = 5;
  localparam int unsigned CMD_NOT_A   = 6;
  localparam int unsigned CMD_NOT_B   = 7;
  localparam int unsigned CMD_SHR1_A  = 8;
  localparam int unsigned CMD_SHL1_A  = 9;
  localparam int unsigned CMD_SHR1_B  = 10;
  localparam int unsigned CMD_SHL1_B  = 11;
  localparam int unsigned CMD_ROL_A_B = 12;
  localparam int unsigned CMD_ROR_A_B = 13;

  // INP_VALID encodings: bit0 = OPA valid, bit1 = OPB valid
  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic e;
    logic l;
    logic err;
  } flags_t;

  // True when the presented operands cover what the command needs.
  // No valid operand at all is always an error, whatever the command.
  function automatic logic iv_ok(input logic [1:0] need, input logic [1:0] iv);
    return (iv != IV_NONE) && ((iv & need) == need);
  endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// Operand-registering stage of the ALU multiplier; product is formed from the registered operands.
// Latency: operands captured at the issuing edge, product consumed by the output bank one edge later.
// Backpressure: none; CE=0 freezes the stage, RST clears it (cancels an in-flight multiply).
//
// Ports: CLK, RST (async, active-high), CE; in_vld/sel_inc/opa/opb from the decode;
//        out_vld/prod (2*WIDTH_OP bits, truncated) toward the output register bank.
module alu_mul_stage #(
  parameter int WIDTH_OP = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  in_vld,
  input  logic                  sel_inc,   // 1: (A+1)*(B+1), 0: ((A<<1) mod 2^W)*B
  input  logic [WIDTH_OP-1:0]   opa,
  input  logic [WIDTH_OP-1:0]   opb,
  output logic                  out_vld,
  output logic [2*WIDTH_OP-1:0] prod
);

  localparam int XW = WIDTH_OP + 1;
  localparam int RW = 2 * WIDTH_OP;

  logic [XW-1:0] x_d, y_d, x_q, y_q;
  logic          vld_q;

  // Operands are pre-conditioned before registering; A+1 needs the extra bit,
  // while the shifted A deliberately drops its MSB inside the W-bit concatenation.
  assign x_d = sel_inc ? ({1'b0, opa} + XW'(1)) : {1'b0, opa << 1};
  assign y_d = sel_inc ? ({1'b0, opb} + XW'(1)) : {1'b0, opb};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (CE) begin
      vld_q <= in_vld;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign out_vld = vld_q;
  // Multiplying at RW bits gives the required truncation to 2W bits directly.
  assign prod    = RW'(x_q) * RW'(y_q);

endmodule

// File: rtl/alu_design.sv
// Registered unsigned ALU: arithmetic/logical ops, compare flags, operand-valid checking, error flag.
// Latency: 1 edge for most ops, 2 for multiplies; an op right behind a multiply slips one edge.
// Backpressure: none; CE=0 freezes every register, RST asynchronously clears all state.
//
// Ports: CLK, RST, CE; MODE (1 arith / 0 logic), CMD, INP_VALID (bit0 A, bit1 B), OPA, OPB, CIN;
//        RES (2*WIDTH_OP, zero-extended), COUT, OFLOW, G, E, L, ERR.
module alu_design
  import alu_design_pkg::*;
#(
  parameter int WIDTH_OP  = 8,
  parameter int WIDTH_CMD = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  MODE,
  input  logic [WIDTH_CMD-1:0]  CMD,
  input  logic [1:0]            INP_VALID,
  input  logic [WIDTH_OP-1:0]   OPA,
  input  logic [WIDTH_OP-1:0]   OPB,
  input  logic                  CIN,
  output logic [2*WIDTH_OP-1:0] RES,
  output logic                  COUT,
  output logic                  OFLOW,
  output logic                  G,
  output logic                  E,
  output logic                  L,
  output logic                  ERR
);

  localparam int RW = 2 * WIDTH_OP;
  localparam int XW = WIDTH_OP + 1;
  localparam int SH = $clog2(WIDTH_OP);

  logic [31:0]         cmd_ext;
  logic [XW-1:0]       opa_x, opb_x;
  logic [SH-1:0]       rot_amt;
  logic                rot_hi;
  logic [WIDTH_OP-1:0] rol_a, ror_a;

  // Decode outputs
  logic [1:0]          need;
  logic                known;
  logic                use_wide;
  logic [XW-1:0]       wide;
  logic [WIDTH_OP-1:0] narrow;
  flags_t              nf;
  logic [RW-1:0]       nxt_res;

  // Multiplier path
  logic                is_mul;
  logic                mul_vld;
  logic [RW-1:0]       mul_prod;

  // Output bank plus a one-entry slip slot for an op that collides with a multiply result
  logic [RW-1:0]       res_q, pend_res;
  flags_t              flg_q, pend_flg;
  logic                pend_vld;

  // Widen CMD so that codes above the listed ones fall into the default (error) arms.
  assign cmd_ext = 32'(CMD);
  assign opa_x   = {1'b0, OPA};
  assign opb_x   = {1'b0, OPB};

  assign rot_amt = OPB[SH-1:0];
  assign rot_hi  = |(OPB >> SH);
  assign rol_a   = (OPA << rot_amt) | (OPA >> (WIDTH_OP - int'(rot_amt)));
  assign ror_a   = (OPA >> rot_amt) | (OPA << (WIDTH_OP - int'(rot_amt)));

  // Only a properly qualified multiply takes the 2-edge path; a multiply with
  // bad operand-valid bits is reported as a plain 1-edge error.
  assign is_mul = (MODE == MODE_ARITH) &&
                  ((cmd_ext == CMD_MUL_INC) || (cmd_ext == CMD_MUL_SHL)) &&
                  iv_ok(IV_AB, INP_VALID);

  always_comb begin
    need     = IV_AB;
    known    = 1'b1;
    use_wide = 1'b0;
    wide     = '0;
    narrow   = '0;
    nf       = '0;
    if (MODE == MODE_ARITH) begin
      case (cmd_ext)
        CMD_ADD: begin
          use_wide = 1'b1;
          wide     = opa_x + opb_x;
          nf.cout  = wide[WIDTH_OP];
        end
        CMD_SUB: begin
          narrow   = OPA - OPB;
          nf.oflow = (OPA < OPB);
        end
        CMD_ADD_CIN: begin
          use_wide = 1'b1;
          wide     = opa_x + opb_x + XW'(CIN);
          nf.cout  = wide[WIDTH_OP];
        end
        CMD_SUB_CIN: begin
          narrow   = OPA - OPB - WIDTH_OP'(CIN);
          nf.oflow = (opa_x < (opb_x + XW'(CIN)));
        end
        CMD_INC_A: begin
          need     = IV_A;
          use_wide = 1'b1;
          wide     = opa_x + XW'(1);
          nf.cout  = wide[WIDTH_OP];
        end
        CMD_DEC_A: begin
          need     = IV_A;
          narrow   = OPA - WIDTH_OP'(1);
          nf.oflow = (OPA == '0);
        end
        CMD_INC_B: begin
          need     = IV_B;
          use_wide = 1'b1;
          wide     = opb_x + XW'(1);
          nf.cout  = wide[WIDTH_OP];
        end
        CMD_DEC_B: begin
          need     = IV_B;
          narrow   = OPB - WIDTH_OP'(1);
          nf.oflow = (OPB == '0);
        end
        CMD_CMP: begin
          nf.g = (OPA > OPB);
          nf.e = (OPA == OPB);
          nf.l = (OPA < OPB);
        end
        CMD_MUL_INC, CMD_MUL_SHL: begin
          // Result comes from alu_mul_stage; only the operand check matters here.
        end
        default: known = 1'b0;
      endcase
    end else begin
      case (cmd_ext)
        CMD_AND:    narrow = OPA & OPB;
        CMD_NAND:   narrow = ~(OPA & OPB);
        CMD_OR:     narrow = OPA | OPB;
        CMD_NOR:    narrow = ~(OPA | OPB);
        CMD_XOR:    narrow = OPA ^ OPB;
        CMD_XNOR:   narrow = ~(OPA ^ OPB);
        CMD_NOT_A:  begin need = IV_A; narrow = ~OPA;    end
        CMD_NOT_B:  begin need = IV_B; narrow = ~OPB;    end
        CMD_SHR1_A: begin need = IV_A; narrow = OPA >> 1; end
        CMD_SHL1_A: begin need = IV_A; narrow = OPA << 1; end
        CMD_SHR1_B: begin need = IV_B; narrow = OPB >> 1; end
        CMD_SHL1_B: begin need = IV_B; narrow = OPB << 1; end
        // Out-of-range rotate amounts flag an error but still deliver the rotate.
        CMD_ROL_A_B: begin narrow = rol_a; nf.err = rot_hi; end
        CMD_ROR_A_B: begin narrow = ror_a; nf.err = rot_hi; end
        default: known = 1'b0;
      endcase
    end
    if (!known || !iv_ok(need, INP_VALID)) begin
      use_wide = 1'b0;
      wide     = '0;
      narrow   = '0;
      nf       = '0;
      nf.err   = 1'b1;
    end
    nxt_res = use_wide ? RW'(wide) : RW'(narrow);
  end

  alu_mul_stage #(.WIDTH_OP(WIDTH_OP)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .in_vld  (is_mul),
    .sel_inc (cmd_ext == CMD_MUL_INC),
    .opa     (OPA),
    .opb     (OPB),
    .out_vld (mul_vld),
    .prod    (mul_prod)
  );

  // Priority: a finishing multiply owns the bank, then a slipped op, then the
  // freshly sampled op. A non-multiply that cannot write this edge is parked in
  // the slip slot; order is always preserved. A multiply issue leaves RES as is.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_q    <= '0;
      flg_q    <= '0;
      pend_vld <= 1'b0;
      pend_res <= '0;
      pend_flg <= '0;
    end else if (CE) begin
      if (mul_vld) begin
        res_q <= mul_prod;
        flg_q <= '0;
      end else if (pend_vld) begin
        res_q <= pend_res;
        flg_q <= pend_flg;
      end else if (!is_mul) begin
        res_q <= nxt_res;
        flg_q <= nf;
      end
      if (!is_mul && (mul_vld || pend_vld)) begin
        pend_vld <= 1'b1;
        pend_res <= nxt_res;
        pend_flg <= nf;
      end else begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign RES   = res_q;
  assign COUT  = flg_q.cout;
  assign OFLOW = flg_q.oflow;
  assign G     = flg_q.g;
  assign E     = flg_q.e;
  assign L     = flg_q.l;
  assign ERR   = flg_q.err;

endmodule

// File: tb/tb_alu_design.sv
// Scoreboard bench for alu_design: driver pushes model results tagged with their arrival edge,
// an independent monitor pops and compares after every rising edge.
// Stimulus: directed cases followed by randomized operations, CE gaps and reset pulses.
module tb_alu_design;

  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST, CE, MODE, CIN;
  logic [3:0]     CMD;
  logic [1:0]     INP_VALID;
  logic [W-1:0]   OPA, OPB;
  logic [2*W-1:0] RES;
  logic           COUT, OFLOW, G, E, L, ERR;

  typedef struct {
    int          arr;   // count of enabled edges at which this result must be visible
    logic [15:0] res;
    logic        cout;
    logic        oflow;
    logic        g;
    logic        e;
    logic        l;
    logic        err;
  } exp_t;

  exp_t scb[$];
  exp_t cur;
  int   checks   = 0;
  int   errors   = 0;
  int   drv_edge = 0;
  int   mon_edge = 0;
  int   last_arr = 0;

  alu_design #(.WIDTH_OP(W), .WIDTH_CMD(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .MODE      (MODE),
    .CMD       (CMD),
    .INP_VALID (INP_VALID),
    .OPA       (OPA),
    .OPB       (OPB),
    .CIN       (CIN),
    .RES       (RES),
    .COUT      (COUT),
    .OFLOW     (OFLOW),
    .G         (G),
    .E         (E),
    .L         (L),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t zero_exp();
    exp_t x;
    x = '{default: 0};
    return x;
  endfunction

  // Behavioural model straight from the operation table, using integer arithmetic.
  function automatic exp_t ref_model(input bit mode, input int cmd, input int iv,
                                     input int a, input int b, input int cin);
    exp_t x;
    int   r, need, s;
    bit   known;
    x = '{default: 0};
    r = 0; need = 3; known = 1; s = b % 8;
    if (mode) begin
      case (cmd)
        0:  begin r = a + b;               x.cout  = (r >= 256); end
        1:  begin r = (a - b + 256) % 256; x.oflow = (a < b); end
        2:  begin r = a + b + cin;         x.cout  = (r >= 256); end
        3:  begin r = (a - b - cin + 512) % 256; x.oflow = (a < b + cin); end
        4:  begin need = 1; r = a + 1;             x.cout  = (r >= 256); end
        5:  begin need = 1; r = (a + 255) % 256;   x.oflow = (a == 0); end
        6:  begin need = 2; r = b + 1;             x.cout  = (r >= 256); end
        7:  begin need = 2; r = (b + 255) % 256;   x.oflow = (b == 0); end
        8:  begin r = 0; x.g = (a > b); x.e = (a == b); x.l = (a < b); end
        9:  r = ((a + 1) * (b + 1)) % 65536;
        10: r = ((a * 2) % 256) * b;
        default: known = 0;
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = 255 - (a & b);
        2:  r = a | b;
        3:  r = 255 - (a | b);
        4:  r = a ^ b;
        5:  r = 255 - (a ^ b);
        6:  begin need = 1; r = 255 - a; end
        7:  begin need = 2; r = 255 - b; end
        8:  begin need = 1; r = a / 2; end
        9:  begin need = 1; r = (a * 2) % 256; end
        10: begin need = 2; r = b / 2; end
        11: begin need = 2; r = (b * 2) % 256; end
        12: begin r = a; repeat (s) r = (r * 2) % 256 + r / 128;   x.err = (b >= 8); end
        13: begin r = a; repeat (s) r = r / 2 + (r % 2) * 128;    x.err = (b >= 8); end
        default: known = 0;
      endcase
    end
    x.res = 16'(r);
    if (!known || iv == 0 || ((iv & need) != need)) begin
      x = '{default: 0};
      x.err = 1'b1;
    end
    return x;
  endfunction

  task automatic check(input string nm, input exp_t x);
    checks++;
    if (RES !== x.res || COUT !== x.cout || OFLOW !== x.oflow || G !== x.g ||
        E !== x.e || L !== x.l || ERR !== x.err) begin
      errors++;
      $display("FAIL %s t=%0t edge=%0d: got RES=%h C=%b O=%b G=%b E=%b L=%b ERR=%b, want RES=%h C=%b O=%b G=%b E=%b L=%b ERR=%b",
               nm, $time, mon_edge, RES, COUT, OFLOW, G, E, L, ERR,
               x.res, x.cout, x.oflow, x.g, x.e, x.l, x.err);
    end
  endtask

  // Drive one cycle of inputs; with CE=1 this is an issued operation whose
  // result arrives at its natural edge, or one edge after the previous result.
  task automatic issue(input bit ce, input bit mode, input int cmd, input int iv,
                       input int a, input int b, input bit cin);
    exp_t x;
    int   nat;
    @(negedge CLK);
    CE = ce; MODE = mode; CMD = 4'(cmd); INP_VALID = 2'(iv);
    OPA = 8'(a); OPB = 8'(b); CIN = cin;
    if (ce) begin
      drv_edge++;
      x     = ref_model(mode, cmd, iv, a, b, cin);
      nat   = drv_edge + ((mode && (cmd == 9 || cmd == 10) && iv == 3) ? 1 : 0);
      x.arr = (nat > last_arr) ? nat : last_arr + 1;
      last_arr = x.arr;
      scb.push_back(x);
    end
  endtask

  task automatic idle_rand();
    issue(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
  endtask

  // Reset pulse spanning one rising edge, with CE high to show reset dominates.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    CE  = 1'b1;
    scb.delete();
    last_arr = drv_edge;
    #1 check("rst_async", zero_exp());
    @(negedge CLK);
    RST = 1'b0;
    CE  = 1'b0;
  endtask

  // Monitor: after every rising edge, retire due results and compare the held outputs.
  initial begin
    cur = zero_exp();
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        cur = zero_exp();
      end else begin
        if (CE) mon_edge++;
        while (scb.size() > 0 && scb[0].arr <= mon_edge) cur = scb.pop_front();
      end
      check("mon", cur);
    end
  end

  initial begin
    RST = 1'b1; CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = '0;
    OPA = '0; OPB = '0; CIN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // ADD with carry out
    issue(1, 1, 0, 3, 'hFF, 'h01, 0);
    // CMP less, then equal
    issue(1, 1, 8, 3, 5, 9, 0);
    issue(1, 1, 8, 3, 7, 7, 0);
    // MUL_INC 3,4 followed by colliding ops
    issue(1, 1, 9, 3, 3, 4, 0);
    issue(1, 0, 0, 3, 'hF0, 'h3C, 0);
    issue(1, 1, 2, 3, 200, 100, 1);
    repeat (2) idle_rand();
    // MUL_INC cancelled by reset, outputs must stay zero
    issue(1, 1, 9, 3, 3, 4, 0);
    do_reset();
    repeat (3) idle_rand();
    // Rotate left, in range then with high OPB bits
    issue(1, 0, 12, 3, 'h81, 'h01, 0);
    issue(1, 0, 12, 3, 'h81, 'h11, 0);
    issue(1, 0, 13, 3, 'h81, 'h03, 0);
    // Operand-valid error and unlisted command
    issue(1, 1, 0, 1, 'h12, 'h34, 0);
    issue(1, 0, 15, 3, 'h12, 'h34, 0);
    issue(1, 1, 4, 0, 'h12, 'h34, 0);
    // SUB with borrow, then CE=0 holds with new inputs
    issue(1, 1, 1, 3, 2, 5, 0);
    repeat (3) idle_rand();
    // Boundary INC/DEC and MUL_SHL pipeline behaviour
    issue(1, 1, 4, 1, 255, 0, 0);
    issue(1, 1, 7, 2, 9, 0, 0);
    issue(1, 1, 10, 3, 200, 3, 0);
    issue(1, 1, 10, 3, 255, 255, 0);
    issue(1, 1, 9, 3, 255, 255, 0);
    issue(1, 1, 3, 3, 5, 5, 1);
    issue(0, 1, 9, 3, 1, 1, 0);
    issue(1, 0, 5, 3, 'hAA, 'h0F, 0);
    issue(1, 1, 6, 2, 0, 255, 0);

    // Randomized traffic with CE gaps and occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        issue(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15),
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 3,
              $urandom_range(0, 255), $urandom_range(0, 255),
              1'($urandom_range(0, 1)));
      end
    end
    repeat (3) idle_rand();
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
